time_counter: RTL and testbench

Time-of-day counter consuming the one-cycle 1 Hz enable from the timer stage and maintaining hours, minutes and seconds as packed BCD for the display path. It advances by one second per enable pulse, emits rollover strobes for downstream alarm/date logic, and accepts a validated time load from the setting UI through a single-cycle request/acknowledge handshake.

---
 rtl/clock_pkg.sv | 38 +++
 rtl/bcd_mod_counter.sv | 34 +++
 rtl/time_counter.sv | 91 +++++++++
 tb/tb_time_counter.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/clock_pkg.sv
// Shared definitions for the time-of-day path: BCD field width, field limits
// and the small BCD helpers used by the counters and the load validation.
package clock_pkg;

    localparam int BCD_W = 8;

    localparam logic [BCD_W-1:0] SEC_MAX     = 8'h59;
    localparam logic [BCD_W-1:0] MIN_MAX     = 8'h59;
    localparam logic [BCD_W-1:0] HOUR_MAX_24 = 8'h23;
    localparam logic [BCD_W-1:0] HOUR_MAX_12 = 8'h11;

    // True when both nibbles are decimal digits and the value does not exceed
    // max. Packed BCD with legal digits orders the same way as its decimal value,
    // so a plain unsigned compare against a BCD limit is exact.
    function automatic logic bcd_in_range(input logic [BCD_W-1:0] val,
                                          input logic [BCD_W-1:0] max);
        return (val[7:4] <= 4'd9) && (val[3:0] <= 4'd9) && (val <= max);
    endfunction

    // Two-digit BCD increment; ones 9 carries into tens. Callers handle the
    // field wrap, so tens never needs to roll over here.
    function automatic logic [BCD_W-1:0] bcd_inc(input logic [BCD_W-1:0] val);
        if (val[3:0] == 4'd9)
            return {val[7:4] + 4'd1, 4'd0};
        else
            return {val[7:4], val[3:0] + 4'd1};
    endfunction

    // Converts a small decimal constant (0..99) into packed BCD.
    function automatic logic [BCD_W-1:0] to_bcd(input int n);
        logic [3:0] tens;
        logic [3:0] ones;
        tens = 4'(n / 10);
        ones = 4'(n % 10);
        return {tens, ones};
    endfunction

endpackage

// File: rtl/bcd_mod_counter.sv
// Two-digit packed-BCD counter that wraps from MAX back to 00. Load has
// priority over increment; wrap flags the increment that rolls the field over
// so counters can be chained wrap -> inc.
module bcd_mod_counter
    import clock_pkg::*;
#(
    parameter logic [BCD_W-1:0] MAX = SEC_MAX
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             load,
    input  logic [BCD_W-1:0] load_val,
    output logic [BCD_W-1:0] value,
    output logic             wrap
);

    logic at_max;

    assign at_max = (value == MAX);
    assign wrap   = inc & at_max;

    // Field register: reset to 00, then load, then count with wrap at MAX.
    always_ff @(posedge clk) begin
        if (rst) begin
            value <= '0;
        end else if (load) begin
            value <= load_val;
        end else if (inc) begin
            value <= at_max ? '0 : bcd_inc(value);
        end
    end

endmodule

// File: rtl/time_counter.sv
// Time-of-day counter: hh:mm:ss in packed BCD advanced by the 1 Hz strobe,
// with rollover strobes for alarm/date logic and a validated single-cycle load
// from the setting UI. Priority is rst > load request > advance.
module time_counter
    import clock_pkg::*;
#(
    parameter int HOUR_MAX = 23
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en_1hz,
    input  logic             run,
    input  logic             set_req,
    input  logic [BCD_W-1:0] set_hh,
    input  logic [BCD_W-1:0] set_mm,
    input  logic [BCD_W-1:0] set_ss,
    output logic             set_ack,
    output logic             set_err,
    output logic [BCD_W-1:0] hour_bcd,
    output logic [BCD_W-1:0] min_bcd,
    output logic [BCD_W-1:0] sec_bcd,
    output logic             min_tick,
    output logic             hour_tick,
    output logic             day_tick
);

    localparam logic [BCD_W-1:0] HOUR_MAX_BCD = to_bcd(HOUR_MAX);

    logic set_valid;
    logic do_load;
    logic advance;
    logic sec_wrap;
    logic min_wrap;
    logic hour_wrap;

    // A pending request always blocks the advance, even when it is rejected,
    // so a colliding second is dropped and no strobe can come from a load.
    assign set_valid = bcd_in_range(set_hh, HOUR_MAX_BCD)
                     & bcd_in_range(set_mm, MIN_MAX)
                     & bcd_in_range(set_ss, SEC_MAX);
    assign do_load   = set_req & set_valid;
    assign advance   = en_1hz & run & ~set_req;

    bcd_mod_counter #(.MAX(SEC_MAX)) u_sec (
        .clk      (clk),
        .rst      (rst),
        .inc      (advance),
        .load     (do_load),
        .load_val (set_ss),
        .value    (sec_bcd),
        .wrap     (sec_wrap)
    );

    bcd_mod_counter #(.MAX(MIN_MAX)) u_min (
        .clk      (clk),
        .rst      (rst),
        .inc      (sec_wrap),
        .load     (do_load),
        .load_val (set_mm),
        .value    (min_bcd),
        .wrap     (min_wrap)
    );

    bcd_mod_counter #(.MAX(HOUR_MAX_BCD)) u_hour (
        .clk      (clk),
        .rst      (rst),
        .inc      (min_wrap),
        .load     (do_load),
        .load_val (set_hh),
        .value    (hour_bcd),
        .wrap     (hour_wrap)
    );

    // Strobe and handshake registers, aligned with the field update they report.
    always_ff @(posedge clk) begin
        if (rst) begin
            set_ack   <= 1'b0;
            set_err   <= 1'b0;
            min_tick  <= 1'b0;
            hour_tick <= 1'b0;
            day_tick  <= 1'b0;
        end else begin
            set_ack   <= do_load;
            set_err   <= set_req & ~set_valid;
            min_tick  <= sec_wrap;
            hour_tick <= min_wrap;
            day_tick  <= hour_wrap;
        end
    end

endmodule

// File: tb/tb_time_counter.sv
// Bench for time_counter: a 24 h and a 12 h instance share one stimulus
// stream; a seconds-of-day reference model predicts each one.
module tb_time_counter;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       en_1hz = 1'b0;
    logic       run = 1'b0;
    logic       set_req = 1'b0;
    logic [7:0] set_hh = 8'h00;
    logic [7:0] set_mm = 8'h00;
    logic [7:0] set_ss = 8'h00;

    logic [7:0] hh_a, mm_a, ss_a, hh_b, mm_b, ss_b;
    logic       ack_a, err_a, mt_a, ht_a, dt_a;
    logic       ack_b, err_b, mt_b, ht_b, dt_b;

    int n_checks = 0;
    int n_fail   = 0;

    int hmax [2] = '{23, 11};
    int tsec [2] = '{0, 0};
    logic [4:0] exp_strb [2];

    always #5 clk = ~clk;

    time_counter #(.HOUR_MAX(23)) u_dut24 (
        .clk(clk), .rst(rst), .en_1hz(en_1hz), .run(run), .set_req(set_req),
        .set_hh(set_hh), .set_mm(set_mm), .set_ss(set_ss),
        .set_ack(ack_a), .set_err(err_a),
        .hour_bcd(hh_a), .min_bcd(mm_a), .sec_bcd(ss_a),
        .min_tick(mt_a), .hour_tick(ht_a), .day_tick(dt_a)
    );

    time_counter #(.HOUR_MAX(11)) u_dut12 (
        .clk(clk), .rst(rst), .en_1hz(en_1hz), .run(run), .set_req(set_req),
        .set_hh(set_hh), .set_mm(set_mm), .set_ss(set_ss),
        .set_ack(ack_b), .set_err(err_b),
        .hour_bcd(hh_b), .min_bcd(mm_b), .sec_bcd(ss_b),
        .min_tick(mt_b), .hour_tick(ht_b), .day_tick(dt_b)
    );

    function automatic logic [7:0] bcd(input int v);
        return 8'(((v / 10) << 4) | (v % 10));
    endfunction

    function automatic int dec(input logic [7:0] b);
        return int'(b[7:4]) * 10 + int'(b[3:0]);
    endfunction

    function automatic logic [23:0] exp_time(input int d);
        return {bcd(tsec[d] / 3600), bcd((tsec[d] / 60) % 60), bcd(tsec[d] % 60)};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: time kept as seconds since midnight, one day = (hmax+1) hours.
    task automatic model_step(input int d);
        int  h, m, s;
        bit  ok;
        exp_strb[d] = 5'b0;
        if (rst) begin
            tsec[d] = 0;
        end else if (set_req) begin
            ok = (set_hh[7:4] <= 9) && (set_hh[3:0] <= 9) &&
                 (set_mm[7:4] <= 9) && (set_mm[3:0] <= 9) &&
                 (set_ss[7:4] <= 9) && (set_ss[3:0] <= 9);
            h = dec(set_hh); m = dec(set_mm); s = dec(set_ss);
            ok = ok && (h <= hmax[d]) && (m <= 59) && (s <= 59);
            if (ok) begin
                tsec[d] = h * 3600 + m * 60 + s;
                exp_strb[d][4] = 1'b1;
            end else begin
                exp_strb[d][3] = 1'b1;
            end
        end else if (en_1hz && run) begin
            tsec[d] = (tsec[d] + 1) % ((hmax[d] + 1) * 3600);
            exp_strb[d][2] = (tsec[d] % 60 == 0);
            exp_strb[d][1] = (tsec[d] % 3600 == 0);
            exp_strb[d][0] = (tsec[d] == 0);
        end
    endtask

    // One clock: update both models from the sampled inputs, then compare #1 later.
    task automatic cycle();
        @(posedge clk);
        model_step(0);
        model_step(1);
        #1;
        chk("time24", {8'h0, hh_a, mm_a, ss_a}, {8'h0, exp_time(0)});
        chk("strb24", {27'h0, ack_a, err_a, mt_a, ht_a, dt_a}, {27'h0, exp_strb[0]});
        chk("time12", {8'h0, hh_b, mm_b, ss_b}, {8'h0, exp_time(1)});
        chk("strb12", {27'h0, ack_b, err_b, mt_b, ht_b, dt_b}, {27'h0, exp_strb[1]});
    endtask

    task automatic do_load(input logic [7:0] hh, input logic [7:0] mm, input logic [7:0] ss);
        set_req = 1'b1; set_hh = hh; set_mm = mm; set_ss = ss;
        cycle();
        set_req = 1'b0;
    endtask

    task automatic pulses(input int n);
        for (int i = 0; i < n; i++) begin
            en_1hz = 1'b1;
            cycle();
            en_1hz = 1'b0;
        end
    endtask

    initial begin
        int mt_seen;
        int r;

        // Reset with en_1hz high
        rst = 1'b1; en_1hz = 1'b1; run = 1'b1;
        cycle();
        cycle();
        chk("reset_time", {8'h0, hh_a, mm_a, ss_a}, 32'h0);
        rst = 1'b0; en_1hz = 1'b0;
        cycle();

        // Ripple 12:34:58 -> :59 -> 12:35:00
        do_load(8'h12, 8'h34, 8'h58);
        pulses(1);
        chk("ripple59", {8'h0, hh_a, mm_a, ss_a}, 32'h00123459);
        pulses(1);
        chk("ripple00", {8'h0, hh_a, mm_a, ss_a}, 32'h00123500);
        chk("ripple_mt", {31'h0, mt_a}, 32'h1);
        cycle();
        chk("ripple_mt_off", {31'h0, mt_a}, 32'h0);

        // Day wrap on each instance
        do_load(8'h23, 8'h59, 8'h59);
        pulses(1);
        chk("wrap24_strb", {29'h0, mt_a, ht_a, dt_a}, 32'h7);
        do_load(8'h11, 8'h59, 8'h59);
        pulses(1);
        chk("wrap12_strb", {29'h0, mt_b, ht_b, dt_b}, 32'h7);
        chk("wrap12_time", {8'h0, hh_b, mm_b, ss_b}, 32'h0);
        cycle();

        // Invalid loads
        do_load(8'h10, 8'h20, 8'h30);
        do_load(8'h24, 8'h00, 8'h00);
        chk("bad_hh_err", {31'h0, err_a}, 32'h1);
        do_load(8'h05, 8'h5A, 8'h00);
        chk("bad_mm_err", {31'h0, err_a}, 32'h1);
        do_load(8'h05, 8'h00, 8'h60);
        chk("bad_ss_err", {31'h0, err_a}, 32'h1);
        chk("bad_time", {8'h0, hh_a, mm_a, ss_a}, 32'h00102030);

        // Collision: load wins, no advance, no ticks
        do_load(8'h10, 8'h00, 8'h05);
        en_1hz = 1'b1;
        do_load(8'h07, 8'h08, 8'h09);
        en_1hz = 1'b0;
        chk("collide_time", {8'h0, hh_a, mm_a, ss_a}, 32'h00070809);

        // Held request repeats
        set_req = 1'b1; set_hh = 8'h01; set_mm = 8'h02; set_ss = 8'h03;
        cycle(); cycle(); cycle();
        set_req = 1'b0;

        // Hold with run=0, loads still accepted
        run = 1'b0;
        pulses(5);
        chk("hold_time", {8'h0, hh_a, mm_a, ss_a}, 32'h00010203);
        do_load(8'h00, 8'h00, 8'h00);
        run = 1'b1;

        // 61 consecutive strobes from 00:00:00
        mt_seen = 0;
        en_1hz = 1'b1;
        for (int i = 0; i < 61; i++) begin
            cycle();
            if (mt_a) mt_seen++;
        end
        en_1hz = 1'b0;
        chk("run61_time", {8'h0, hh_a, mm_a, ss_a}, 32'h00000101);
        chk("run61_mt", mt_seen, 1);

        // Reset during a load request: no ack/err
        rst = 1'b1; set_req = 1'b1; set_hh = 8'h05;
        cycle();
        rst = 1'b0; set_req = 1'b0;
        chk("rst_load", {30'h0, ack_a, err_a}, 32'h0);

        // Randomized traffic, starting near a day boundary
        do_load(8'h11, 8'h58, 8'h30);
        for (int i = 0; i < 3000; i++) begin
            r = int'($urandom_range(0, 99));
            rst     = (r == 0);
            en_1hz  = ($urandom_range(0, 9) < 8);
            run     = ($urandom_range(0, 9) < 9);
            set_req = ($urandom_range(0, 49) == 0);
            if ($urandom_range(0, 1) == 1) begin
                set_hh = bcd(int'($urandom_range(0, 23)));
                set_mm = bcd(int'($urandom_range(0, 59)));
                set_ss = bcd(int'($urandom_range(50, 59)));
            end else begin
                set_hh = 8'($urandom);
                set_mm = 8'($urandom);
                set_ss = 8'($urandom);
            end
            cycle();
        end
        rst = 1'b0; en_1hz = 1'b0; set_req = 1'b0;
        cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
